// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fib_pkg
// Brief    : Shared constants, FSM state type and helpers for the Fibonacci
//            generator and its BCD conversion stage.
// Revision : 1.0 - initial release
// ============================================================================
package fib_pkg;

  localparam int FIB_W      = 12;
  localparam int BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fib_bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : fib_bcd_add3
// Brief    : Double-dabble correction cell: adds 3 to a BCD nibble >= 5.
// Revision : 1.0 - initial release
// ============================================================================
module fib_bcd_add3 (
  input  logic [3:0] din,
  input  logic       unused_tie,
  output logic [3:0] dout
);

  logic w_adjust;

  // No carry-out: a valid digit (<=9) plus 3 still fits in 4 bits.
  assign w_adjust = (din >= 4'd5) & ~unused_tie;
  assign dout     = w_adjust ? (din + 4'd3) : din;

endmodule
`default_nettype wire

// File: rtl/fib_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : fib_bcd_conv
// Brief    : Serial double-dabble binary-to-BCD converter, one bit per cycle,
//            valid/ready on both sides. Optional macro FIB_BCD_WRAP_EN adds
//            a wrap (value decreased) flag on each result.
// Revision : 1.0 - initial release
// ============================================================================
module fib_bcd_conv
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*DIGITS-1:0]     bcd_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    wrap_flag
);

  localparam int c_bcd_w = bcd_width(DIGITS);
  localparam int c_cnt_w = $clog2(DATA_W + 1);

  conv_state_t          r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_bcd_w-1:0]   r_bcd;
  logic [DATA_W-1:0]    r_bin;

  logic [c_bcd_w-1:0]   w_bcd_adj;
  logic [c_bcd_w-1:0]   w_bcd_next;
  logic [DATA_W-1:0]    w_bin_next;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
      fib_bcd_add3 u_add3 (
        .din        (r_bcd[4*k +: 4]),
        .unused_tie (1'b0),
        .dout       (w_bcd_adj[4*k +: 4])
      );
    end
  endgenerate

  assign {w_bcd_next, w_bin_next} = {w_bcd_adj, r_bin} << 1;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

`ifdef FIB_BCD_WRAP_EN
  logic [DATA_W-1:0] r_prev;
  logic              r_wrap_cmp;
  logic              r_wrap_flag;
  assign wrap_flag = r_wrap_flag;
`else
  assign wrap_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_bin   <= '0;
      bcd_out <= '0;
`ifdef FIB_BCD_WRAP_EN
      r_prev      <= '0;
      r_wrap_cmp  <= 1'b0;
      r_wrap_flag <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bin   <= in_data;
            r_bcd   <= '0;
            r_cnt   <= c_cnt_w'(DATA_W);
            r_state <= SHIFT;
`ifdef FIB_BCD_WRAP_EN
            r_wrap_cmp <= (in_data < r_prev);
            r_prev     <= in_data;
`endif
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= w_bin_next;
          r_cnt <= r_cnt - c_cnt_w'(1);
          // Last bit shifts in this cycle; publish the post-shift digits.
          if (r_cnt == c_cnt_w'(1)) begin
            bcd_out <= w_bcd_next;
            r_state <= DONE;
`ifdef FIB_BCD_WRAP_EN
            r_wrap_flag <= r_wrap_cmp;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
`ifdef FIB_BCD_WRAP_EN
            r_wrap_flag <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fib_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_bcd_conv
// Brief    : Self-checking bench for fib_bcd_conv against an arithmetic
//            decimal-digit model (wrap expectation follows FIB_BCD_WRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_bcd_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] bcd_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        wrap_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int prev = 0;

  fib_bcd_conv dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wrap_flag (wrap_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic send(input logic [11:0] v, input bit keep, output int acc, output logic exp_w);
    in_data  = v;
    in_valid = 1'b1;
    acc      = -1;
    exp_w    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
`ifdef FIB_BCD_WRAP_EN
    exp_w = (int'(v) < prev);
`else
    exp_w = 1'b0;
`endif
    prev = int'(v);
  endtask

  task automatic recv(input logic [11:0] v, input logic exp_w, input int acc,
                      input int hold, input bit poke);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk("out_timeout", 0, 1);
      return;
    end
    chk("latency", cyc - acc, 12);
    chk("bcd", bcd_out, to_bcd(int'(v)));
    chk("wrap", wrap_flag, exp_w);
    chk("in_ready_done", in_ready, 0);
    for (int j = 0; j < hold; j++) begin
      if (poke && j == 1) begin
        in_data  = 12'd5;
        in_valid = 1'b1;
      end
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_bcd", bcd_out, to_bcd(int'(v)));
      chk("hold_in_ready", in_ready, 0);
    end
    if (hold > 0) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  task automatic conv(input logic [11:0] v, input int hold, input bit poke);
    int   acc;
    logic ew;
    out_ready = (hold == 0);
    send(v, 1'b0, acc, ew);
    if (acc >= 0) recv(v, ew, acc, hold, poke);
  endtask

  initial begin
    int   acc, last, cnt;
    logic ew;
    int   fib [18];

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_wrap", wrap_flag, 0);
    rst = 1'b1;
    prev = 0;

    conv(12'd233, 0, 1'b0);
    conv(12'd0, 0, 1'b0);
    conv(12'd4095, 0, 1'b0);
    conv(12'd1597, 5, 1'b1);

    // Abort a conversion mid-way with a one-cycle reset.
    out_ready = 1'b1;
    send(12'd2000, 1'b0, acc, ew);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    prev = 0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("abort_no_output", cnt, 0);

    conv(12'd1597, 0, 1'b0);
    conv(12'd2584, 0, 1'b0);
    conv(12'd85, 0, 1'b0);

    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 18; i++) fib[i] = fib[i-1] + fib[i-2];
    out_ready = 1'b1;
    last = 0;
    for (int i = 0; i < 18; i++) begin
      send(12'(fib[i]), 1'b1, acc, ew);
      if (acc < 0) break;
      if (i > 0) chk("stream_spacing", acc - last, 14);
      last = acc;
      recv(12'(fib[i]), ew, acc, 0, 1'b0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 20; i++) begin
      conv(12'($urandom_range(0, 4095)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
